alu_writeback: RTL and testbench

- Consumer end of the 8-bit ALU result interface (res_out, car_out, zero, jump). Sits directly after the ALU.
- Accepts one ALU result per handshake and performs register-file writeback.
- Holds the carry and zero flag registers, owns the program counter, and resolves BEQ branches.
- Sequences the multi-cycle load/store path (op 6) against a simple memory handshake.

---
 rtl/alu_writeback.sv | 145 ++++++++++++++
 tb/tb_alu_writeback.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU result consumer: register writeback, flags, PC, BEQ resolution
// and the load/store memory handshake.
module alu_writeback #(
    parameter int reg_width = 8,
    parameter int op_width  = 3,
    parameter int pc_width  = 8,
    parameter int max_wait  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [op_width-1:0]  op_in,
    input  logic [2:0]           dst_in,
    input  logic [reg_width-1:0] res_in,
    input  logic [reg_width-1:0] car_in,
    input  logic                 zero_in,
    input  logic                 jump_in,
    input  logic [reg_width-1:0] off_in,
    output logic                 rf_we_out,
    output logic [2:0]           rf_addr_out,
    output logic [reg_width-1:0] rf_data_out,
    output logic [reg_width-1:0] car_reg_out,
    output logic                 zero_flag_out,
    output logic [pc_width-1:0]  pc_out,
    output logic                 flush_out,
    output logic                 mem_req_out,
    output logic [reg_width-1:0] mem_addr_out,
    input  logic                 mem_ack_in,
    input  logic [reg_width-1:0] mem_data_in,
    output logic                 err_out
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(max_wait - 1);
    localparam logic [op_width-1:0] OP_ADD = op_width'(2);
    localparam logic [op_width-1:0] OP_BEQ = op_width'(5);
    localparam logic [op_width-1:0] OP_MEM = op_width'(6);

    state_t               state_q, state_d;
    logic                 ready_q;
    logic [7:0]           wait_q;
    logic [2:0]           ld_dst_q;
    logic [pc_width-1:0]  pc_q;
    logic [pc_width-1:0]  off_ext;
    logic                 accept;
    logic                 in_wait;
    logic                 wait_done;
    logic                 is_alu, is_beq, is_mem, is_rsv;

    assign accept    = valid_in && ready_q;
    assign in_wait   = state_q == MEM_WAIT;
    assign wait_done = mem_ack_in || (wait_q == WAIT_LAST);
    assign off_ext   = pc_width'($signed(off_in));
    assign is_alu    = op_in < OP_BEQ;
    assign is_beq    = op_in == OP_BEQ;
    assign is_mem    = op_in == OP_MEM;
    assign is_rsv    = op_in > OP_MEM;
    assign ready_out = ready_q;
    assign pc_out    = pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (accept && is_mem)
                    state_d = MEM_WAIT;
                else if (accept && is_beq && jump_in)
                    state_d = FLUSH;
            end
            MEM_WAIT: if (wait_done) state_d = RUN;
            FLUSH:    state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            ready_q       <= 1'b0;
            wait_q        <= '0;
            ld_dst_q      <= '0;
            pc_q          <= '0;
            rf_we_out     <= 1'b0;
            rf_addr_out   <= '0;
            rf_data_out   <= '0;
            car_reg_out   <= '0;
            zero_flag_out <= 1'b0;
            flush_out     <= 1'b0;
            mem_req_out   <= 1'b0;
            mem_addr_out  <= '0;
            err_out       <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= state_d == RUN;
            rf_we_out <= 1'b0;
            flush_out <= 1'b0;
            if (accept) begin
                unique case (1'b1)
                    is_alu: begin
                        rf_we_out     <= 1'b1;
                        rf_addr_out   <= dst_in;
                        rf_data_out   <= res_in;
                        zero_flag_out <= zero_in;
                        if (op_in == OP_ADD) car_reg_out <= car_in;
                        pc_q          <= pc_q + 1'b1;
                    end
                    is_beq: begin
                        pc_q      <= jump_in ? pc_q + off_ext : pc_q + 1'b1;
                        flush_out <= jump_in;
                    end
                    is_mem: begin
                        mem_req_out  <= 1'b1;
                        mem_addr_out <= res_in;
                        ld_dst_q     <= dst_in;
                        wait_q       <= '0;
                    end
                    is_rsv: begin
                        err_out <= 1'b1;
                        pc_q    <= pc_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            // An ack on the final wait cycle takes priority over the timeout
            if (in_wait) begin
                if (mem_ack_in) begin
                    mem_req_out <= 1'b0;
                    rf_we_out   <= 1'b1;
                    rf_addr_out <= ld_dst_q;
                    rf_data_out <= mem_data_in;
                    pc_q        <= pc_q + 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    mem_req_out <= 1'b0;
                    err_out     <= 1'b1;
                    pc_q        <= pc_q + 1'b1;
                end else begin
                    wait_q <= wait_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized self-checking bench for alu_writeback against a
// transaction-level reference model.
module tb_alu_writeback;

    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [2:0] op_in = '0;
    logic [2:0] dst_in = '0;
    logic [7:0] res_in = '0, car_in = '0, off_in = '0;
    logic       zero_in = 1'b0, jump_in = 1'b0;
    logic       rf_we_out;
    logic [2:0] rf_addr_out;
    logic [7:0] rf_data_out, car_reg_out, pc_out, mem_addr_out;
    logic       zero_flag_out, flush_out, mem_req_out, err_out;
    logic       mem_ack_in = 1'b0;
    logic [7:0] mem_data_in = '0;

    int vecs = 0;
    int errs = 0;

    logic       m_we, m_zero, m_flush, m_ready, m_req, m_err, m_inmem;
    logic [2:0] m_addr, m_ld;
    logic [7:0] m_data, m_car, m_maddr;
    int         m_pc, m_waited;

    always #5 clk = ~clk;

    alu_writeback #(.reg_width(8), .op_width(3), .pc_width(8),
                    .max_wait(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .ready_out(ready_out), .op_in(op_in), .dst_in(dst_in),
        .res_in(res_in), .car_in(car_in), .zero_in(zero_in),
        .jump_in(jump_in), .off_in(off_in), .rf_we_out(rf_we_out),
        .rf_addr_out(rf_addr_out), .rf_data_out(rf_data_out),
        .car_reg_out(car_reg_out), .zero_flag_out(zero_flag_out),
        .pc_out(pc_out), .flush_out(flush_out),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in),
        .err_out(err_out)
    );

    function automatic logic [40:0] snap();
        return {rf_we_out, rf_addr_out, rf_data_out, car_reg_out,
                zero_flag_out, pc_out, flush_out, ready_out,
                mem_req_out, mem_addr_out, err_out};
    endfunction

    function automatic logic [40:0] exp_snap();
        return {m_we, m_addr, m_data, m_car, m_zero, m_pc[7:0],
                m_flush, m_ready, m_req, m_maddr, m_err};
    endfunction

    task automatic model_reset();
        m_we = 0; m_zero = 0; m_flush = 0; m_ready = 0; m_req = 0;
        m_err = 0; m_inmem = 0; m_addr = 0; m_ld = 0; m_data = 0;
        m_car = 0; m_maddr = 0; m_pc = 0; m_waited = 0;
    endtask

    // One clock: drive at negedge, model the edge, settle 1 time unit.
    task automatic cycle(input logic v, input logic [2:0] op,
                         input logic [2:0] dst, input logic [7:0] res,
                         input logic [7:0] car, input logic z,
                         input logic j, input logic [7:0] off,
                         input logic ack, input logic [7:0] md);
        logic acc;
        @(negedge clk);
        valid_in = v; op_in = op; dst_in = dst; res_in = res;
        car_in = car; zero_in = z; jump_in = j; off_in = off;
        mem_ack_in = ack; mem_data_in = md;
        @(posedge clk);
        acc = v && m_ready;
        m_we = 0;
        m_flush = 0;
        if (m_inmem) begin
            if (ack) begin
                m_req = 0; m_we = 1; m_addr = m_ld; m_data = md;
                m_pc = (m_pc + 1) % 256; m_inmem = 0;
            end else begin
                m_waited++;
                if (m_waited == MAX_WAIT) begin
                    m_req = 0; m_err = 1;
                    m_pc = (m_pc + 1) % 256; m_inmem = 0;
                end
            end
        end else if (acc) begin
            if (op <= 3'd4) begin
                m_we = 1; m_addr = dst; m_data = res; m_zero = z;
                if (op == 3'd2) m_car = car;
                m_pc = (m_pc + 1) % 256;
            end else if (op == 3'd5) begin
                if (j) begin
                    m_pc = (m_pc + int'($signed(off)) + 256) % 256;
                    m_flush = 1;
                end else begin
                    m_pc = (m_pc + 1) % 256;
                end
            end else if (op == 3'd6) begin
                m_req = 1; m_maddr = res; m_ld = dst;
                m_inmem = 1; m_waited = 0;
            end else begin
                m_err = 1;
                m_pc = (m_pc + 1) % 256;
            end
        end
        m_ready = !m_inmem && !m_flush;
        #1;
    endtask

    task automatic idle(input logic ack, input logic [7:0] md);
        cycle(0, 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), 8'($urandom), ack, md);
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_in = 1'($urandom); op_in = 3'($urandom);
            res_in = 8'($urandom); mem_ack_in = 1'($urandom);
            jump_in = 1'($urandom);
            @(posedge clk); #1;
            vecs++;
            if (snap() !== 41'd0) begin
                errs++;
                $display("FAIL reset_hold[%0d]: got %h want 0", i, snap());
            end
        end
        @(negedge clk);
        valid_in = 0; mem_ack_in = 0;
        rst_n = 1;
        model_reset();
        idle(0, 8'h00);
        vecs++;
        if (ready_out !== 1'b1 || pc_out !== 8'd0) begin
            errs++;
            $display("FAIL reset_release: ready=%b pc=%0d want 1 0",
                     ready_out, pc_out);
        end
    endtask

    task automatic test_add();
        cycle(1, 3'd2, 3'd3, 8'd110, 8'd0, 0, 0, 8'd0, 0, 8'd0);
        vecs++;
        if (snap() !== exp_snap() || rf_data_out !== 8'd110 ||
            pc_out !== 8'd1) begin
            errs++;
            $display("FAIL add_first: got %h want %h", snap(), exp_snap());
        end
        cycle(1, 3'd0, 3'd1, 8'h3C, 8'hFF, 1, 0, 8'd0, 0, 8'd0);
        vecs++;
        if (snap() !== exp_snap() || car_reg_out !== 8'd0) begin
            errs++;
            $display("FAIL and_keeps_car: got %h want %h",
                     snap(), exp_snap());
        end
        for (int i = 0; i < 24; i++) begin
            cycle(1, 3'($urandom_range(0, 4)), 3'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom), 0, 8'($urandom), 0, 8'd0);
            vecs++;
            if (snap() !== exp_snap()) begin
                errs++;
                $display("FAIL alu_rand[%0d]: got %h want %h",
                         i, snap(), exp_snap());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
        for (int i = 0; i < 4; i++) begin
            cycle(1, ops[i], 3'(i), 8'(i + 1), 8'hAA, 0, 0, 8'd0, 0, 8'd0);
            vecs++;
            if (snap() !== exp_snap() || rf_we_out !== 1'b1 ||
                rf_data_out !== 8'(i + 1) || ready_out !== 1'b1) begin
                errs++;
                $display("FAIL b2b[%0d]: got %h want %h",
                         i, snap(), exp_snap());
            end
        end
        idle(0, 8'd0);
        vecs++;
        if (snap() !== exp_snap()) begin
            errs++;
            $display("FAIL b2b_idle: got %h want %h", snap(), exp_snap());
        end
    endtask

    task automatic test_branch();
        int targets [4] = '{5, 2, 255, 1};
        int offs    [4];
        for (int i = 0; i < 4; i++) begin
            offs[i] = (i == 0) ? (5 - m_pc + 256) % 256 :
                      (i == 1) ? 253 : (i == 2) ? 253 : 2;
            cycle(1, 3'd5, 3'd0, 8'd0, 8'd0, 0, 1, 8'(offs[i]), 0, 8'd0);
            vecs++;
            if (snap() !== exp_snap() || pc_out !== 8'(targets[i]) ||
                flush_out !== 1'b1 || ready_out !== 1'b0) begin
                errs++;
                $display("FAIL beq_taken[%0d]: got %h want %h pc %0d",
                         i, snap(), exp_snap(), targets[i]);
            end
            cycle(1, 3'd2, 3'd7, 8'hEE, 8'hEE, 1, 0, 8'd0, 0, 8'd0);
            vecs++;
            if (snap() !== exp_snap() || flush_out !== 1'b0) begin
                errs++;
                $display("FAIL beq_flush_end[%0d]: got %h want %h",
                         i, snap(), exp_snap());
            end
        end
        cycle(1, 3'd5, 3'd0, 8'd0, 8'd0, 0, 0, 8'hF0, 0, 8'd0);
        vecs++;
        if (snap() !== exp_snap() || flush_out !== 1'b0) begin
            errs++;
            $display("FAIL beq_not_taken: got %h want %h",
                     snap(), exp_snap());
        end
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom), 3'($urandom_range(0, 5)), 3'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 0, 8'd0);
            vecs++;
            if (snap() !== exp_snap()) begin
                errs++;
                $display("FAIL mix_rand[%0d]: got %h want %h",
                         i, snap(), exp_snap());
            end
        end
    endtask

    task automatic test_load();
        int req_cycles = 0;
        cycle(1, 3'd6, 3'd6, 8'h40, 8'd0, 0, 0, 8'd0, 1, 8'h11);
        for (int c = 1; c <= 4; c++) begin
            if (mem_req_out) req_cycles++;
            vecs++;
            if (snap() !== exp_snap()) begin
                errs++;
                $display("FAIL load[%0d]: got %h want %h",
                         c, snap(), exp_snap());
            end
            idle(c == 3, 8'hA5);
        end
        vecs++;
        if (req_cycles != 3 || rf_data_out !== 8'hA5 ||
            rf_addr_out !== 3'd6 || err_out !== 1'b0) begin
            errs++;
            $display("FAIL load_result: req=%0d data=%h addr=%0d err=%b want 3 a5 6 0",
                     req_cycles, rf_data_out, rf_addr_out, err_out);
        end
        for (int n = 0; n < 6; n++) begin
            int k = (n == 0) ? MAX_WAIT : $urandom_range(1, MAX_WAIT - 1);
            cycle(1, 3'd6, 3'($urandom), 8'($urandom), 8'd0, 0, 0, 8'd0,
                  1'($urandom), 8'd0);
            for (int c = 1; c <= k + 1; c++) begin
                idle(c == k, 8'($urandom));
                vecs++;
                if (snap() !== exp_snap()) begin
                    errs++;
                    $display("FAIL load_rand[%0d.%0d]: got %h want %h",
                             n, c, snap(), exp_snap());
                end
            end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int writes = 0;
        cycle(1, 3'd6, 3'd2, 8'h80, 8'd0, 0, 0, 8'd0, 0, 8'd0);
        for (int c = 0; c < 20; c++) begin
            if (mem_req_out) req_cycles++;
            if (rf_we_out) writes++;
            vecs++;
            if (snap() !== exp_snap()) begin
                errs++;
                $display("FAIL timeout[%0d]: got %h want %h",
                         c, snap(), exp_snap());
            end
            idle(0, 8'd0);
        end
        vecs++;
        if (req_cycles != MAX_WAIT || writes != 0 || err_out !== 1'b1) begin
            errs++;
            $display("FAIL timeout_result: req=%0d wr=%0d err=%b want 15 0 1",
                     req_cycles, writes, err_out);
        end
    endtask

    task automatic test_reset_midwait();
        cycle(1, 3'd6, 3'd1, 8'h22, 8'd0, 0, 0, 8'd0, 0, 8'd0);
        idle(0, 8'd0);
        idle(0, 8'd0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        model_reset();
        vecs++;
        if (snap() !== 41'd0 || mem_req_out !== 1'b0) begin
            errs++;
            $display("FAIL reset_midwait: got %h want 0", snap());
        end
        @(negedge clk);
        rst_n = 1;
        idle(0, 8'd0);
        vecs++;
        if (snap() !== exp_snap()) begin
            errs++;
            $display("FAIL reset_midwait_release: got %h want %h",
                     snap(), exp_snap());
        end
    endtask

    task automatic test_op7();
        cycle(1, 3'd7, 3'd5, 8'h99, 8'h99, 1, 1, 8'h04, 0, 8'd0);
        vecs++;
        if (snap() !== exp_snap() || err_out !== 1'b1 ||
            rf_we_out !== 1'b0) begin
            errs++;
            $display("FAIL op7: got %h want %h", snap(), exp_snap());
        end
        idle(0, 8'd0);
        vecs++;
        if (err_out !== 1'b1) begin
            errs++;
            $display("FAIL err_sticky: got %b want 1", err_out);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_load();
        test_timeout();
        test_reset_midwait();
        test_op7();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
